// File: rtl/stream_row_loader.sv
// Packs AXI-Stream beats into ROW_LEN slot registers and hands the full row to compute via valid/ack.
// Write pulse 1 cycle after accept; tready low from row close until the row is acked.
module stream_row_loader #(
  parameter int WORD_WIDTH = 32,
  parameter int ROW_LEN    = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WORD_WIDTH-1:0] i_s_tdata,
  input  logic                  i_s_tvalid,
  input  logic                  i_s_tlast,
  output logic                  o_s_tready,
  output logic [ROW_LEN-1:0]    o_wr_en,
  output logic [WORD_WIDTH-1:0] o_wr_data,
  output logic                  o_row_valid,
  input  logic                  i_row_ack,
  output logic                  o_len_err,
  input  logic                  i_err_clr
);

  localparam int IW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(ROW_LEN - 1);

  typedef enum logic [1:0] {FILL, LAST, HOLD} state_t;

  state_t                state, state_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [ROW_LEN-1:0]    wr_en_q, wr_en_nxt;
  logic [WORD_WIDTH-1:0] wr_data_q, wr_data_nxt;
  logic                  len_err_q, len_err_nxt;
  logic                  accept, at_end, err_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FILL;
      idx       <= '0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      len_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      wr_en_q   <= wr_en_nxt;
      wr_data_q <= wr_data_nxt;
      len_err_q <= len_err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    wr_en_nxt   = '0;
    wr_data_nxt = wr_data_q;
    accept      = (state == FILL) && i_s_tvalid;
    at_end      = (idx == LAST_IDX);
    // Early tlast and missing tlast on the last slot are both length errors.
    err_set     = accept && (at_end ? !i_s_tlast : i_s_tlast);

    case (state)
      FILL: begin
        if (accept) begin
          wr_data_nxt = i_s_tdata;
          for (int i = 0; i < ROW_LEN; i++) begin
            wr_en_nxt[i] = (idx == IW'(i));
          end
          if (at_end || i_s_tlast) begin
            state_nxt = LAST;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end
      end
      LAST: state_nxt = HOLD;
      HOLD: begin
        if (i_row_ack) begin
          state_nxt = FILL;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = FILL;
        idx_nxt   = '0;
      end
    endcase

    if (err_set) begin
      len_err_nxt = 1'b1;
    end else if (i_err_clr) begin
      len_err_nxt = 1'b0;
    end else begin
      len_err_nxt = len_err_q;
    end
  end

  // Gated by reset_n so tready drops immediately on async reset assertion.
  assign o_s_tready  = reset_n && (state == FILL);
  assign o_row_valid = (state == HOLD);
  assign o_wr_en     = wr_en_q;
  assign o_wr_data   = wr_data_q;
  assign o_len_err   = len_err_q;

endmodule

// File: tb/tb_stream_row_loader.sv
// Directed bench for stream_row_loader with ROW_LEN=8, WORD_WIDTH=32.
module tb_stream_row_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] tdata;
  logic        tvalid, tlast, tready;
  logic [7:0]  wr_en;
  logic [31:0] wr_data;
  logic        row_valid, row_ack, len_err, err_clr;

  int n_cmp = 0;
  int n_bad = 0;

  stream_row_loader #(.WORD_WIDTH(32), .ROW_LEN(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_s_tdata  (tdata),
    .i_s_tvalid (tvalid),
    .i_s_tlast  (tlast),
    .o_s_tready (tready),
    .o_wr_en    (wr_en),
    .o_wr_data  (wr_data),
    .o_row_valid(row_valid),
    .i_row_ack  (row_ack),
    .o_len_err  (len_err),
    .i_err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic l, input logic [7:0] en);
    tvalid = 1'b1;
    tdata  = d;
    tlast  = l;
    step();
    chk("wr_en", {24'd0, wr_en}, {24'd0, en});
    chk("wr_data", wr_data, d);
  endtask

  // Called in the LAST cycle; walks LAST -> HOLD -> ack -> FILL.
  task automatic finish_row();
    chk("last_tready", {31'd0, tready}, 32'd0);
    chk("last_row_valid", {31'd0, row_valid}, 32'd0);
    tvalid = 1'b0;
    tlast  = 1'b0;
    step();
    chk("hold_row_valid", {31'd0, row_valid}, 32'd1);
    chk("hold_wr_en", {24'd0, wr_en}, 32'd0);
    chk("hold_tready", {31'd0, tready}, 32'd0);
    row_ack = 1'b1;
    step();
    chk("ack_row_valid", {31'd0, row_valid}, 32'd0);
    chk("ack_tready", {31'd0, tready}, 32'd1);
    row_ack = 1'b0;
  endtask

  initial begin
    int hold_bad;
    reset_n = 1'b1;
    tdata   = '0;
    tvalid  = 1'b0;
    tlast   = 1'b0;
    row_ack = 1'b0;
    err_clr = 1'b0;
    #1 reset_n = 1'b0;
    #11;
    chk("rst_tready", {31'd0, tready}, 32'd0);
    chk("rst_wr_en", {24'd0, wr_en}, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_row_valid", {31'd0, row_valid}, 32'd0);
    chk("rst_len_err", {31'd0, len_err}, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("post_rst_tready", {31'd0, tready}, 32'd1);

    // Exact packet, ack held high
    row_ack = 1'b1;
    for (int i = 0; i < 8; i++) beat(32'h10 + i, i == 7, 8'(1 << i));
    row_ack = 1'b0;
    finish_row();
    chk("exact_len_err", {31'd0, len_err}, 32'd0);

    // Backpressure while the row is held
    for (int i = 0; i < 8; i++) beat(32'h20 + i, i == 7, 8'(1 << i));
    tvalid = 1'b1;
    tdata  = 32'hAA;
    tlast  = 1'b0;
    hold_bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tready !== 1'b0 || wr_en !== 8'h00 || row_valid !== 1'b1) hold_bad++;
    end
    chk("bp_hold_cycles_bad", hold_bad, 32'd0);
    row_ack = 1'b1;
    step();
    row_ack = 1'b0;
    chk("bp_ack_tready", {31'd0, tready}, 32'd1);
    chk("bp_ack_row_valid", {31'd0, row_valid}, 32'd0);
    chk("bp_ack_wr_en", {24'd0, wr_en}, 32'd0);
    beat(32'hAA, 1'b0, 8'h01);
    for (int i = 1; i < 8; i++) beat(32'hAA + i, i == 7, 8'(1 << i));
    finish_row();
    chk("bp_len_err", {31'd0, len_err}, 32'd0);

    // Early tlast
    beat(32'h1, 1'b0, 8'h01);
    beat(32'h2, 1'b0, 8'h02);
    chk("early_err_before", {31'd0, len_err}, 32'd0);
    beat(32'h3, 1'b1, 8'h04);
    chk("early_err_set", {31'd0, len_err}, 32'd1);
    finish_row();
    chk("early_err_sticky", {31'd0, len_err}, 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("early_err_clr", {31'd0, len_err}, 32'd0);

    // Late tlast: 16 beats, tlast only on the 16th
    for (int i = 0; i < 8; i++) beat(32'h40 + i, 1'b0, 8'(1 << i));
    chk("late_err_set", {31'd0, len_err}, 32'd1);
    finish_row();
    err_clr = 1'b1;
    beat(32'h48, 1'b0, 8'h01);
    err_clr = 1'b0;
    chk("late_err_clr", {31'd0, len_err}, 32'd0);
    for (int i = 1; i < 8; i++) beat(32'h48 + i, i == 7, 8'(1 << i));
    chk("late_row2_no_err", {31'd0, len_err}, 32'd0);
    finish_row();

    // New error coinciding with clear: error wins
    err_clr = 1'b1;
    beat(32'h55, 1'b1, 8'h01);
    err_clr = 1'b0;
    chk("err_vs_clr", {31'd0, len_err}, 32'd1);
    finish_row();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_clr2", {31'd0, len_err}, 32'd0);

    // Gapped input
    for (int i = 0; i < 8; i++) begin
      beat(32'h60 + i, i == 7, 8'(1 << i));
      if (i < 7) begin
        tvalid = 1'b0;
        tdata  = 32'hDEAD;
        step();
        chk("gap_wr_en", {24'd0, wr_en}, 32'd0);
        chk("gap_wr_data_hold", wr_data, 32'h60 + i);
        chk("gap_row_valid", {31'd0, row_valid}, 32'd0);
      end
    end
    finish_row();

    // Async reset mid-row
    for (int i = 0; i < 5; i++) beat(32'h70 + i, 1'b0, 8'(1 << i));
    #2 reset_n = 1'b0;
    #1;
    chk("mrst_wr_en", {24'd0, wr_en}, 32'd0);
    chk("mrst_row_valid", {31'd0, row_valid}, 32'd0);
    chk("mrst_tready", {31'd0, tready}, 32'd0);
    chk("mrst_wr_data", wr_data, 32'd0);
    tvalid = 1'b1;
    tdata  = 32'h99;
    step();
    chk("mrst_no_accept", {24'd0, wr_en}, 32'd0);
    #3 reset_n = 1'b1;
    beat(32'h77, 1'b0, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_row_loader.md
Name: stream_row_loader

Overview:
- Upstream neighbour of the operand register bank in the GEMM datapath.
- Accepts an AXI-Stream of WORD_WIDTH words and deposits consecutive beats into ROW_LEN slot registers. It drives each slot's data and clock-enable.
- Presents a complete row to the compute stage with a valid/ack handshake.
- Applies backpressure while a finished row is waiting to be consumed, and flags packets whose length does not match ROW_LEN.

Parameters:
- WORD_WIDTH, 32, width of a stream beat and of each slot register.
- ROW_LEN, 8, number of slots per row; legal range 1..256. The slot index width is the local value max(1, $clog2(ROW_LEN)).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- i_s_tdata  input  WORD_WIDTH  stream beat data.
- i_s_tvalid  input  1  stream beat valid.
- i_s_tlast  input  1  marks the final beat of a packet.
- o_s_tready  output  1  loader can accept a beat.
- o_wr_en  output  ROW_LEN  one-hot slot write enable, one bit per slot register clk_en.
- o_wr_data  output  WORD_WIDTH  data shared by all slot registers.
- o_row_valid  output  1  all slots of the current row are loaded and stable.
- i_row_ack  input  1  compute stage has consumed the row.
- o_len_err  output  1  sticky packet-length error.
- i_err_clr  input  1  clears o_len_err.

Behaviour:
- Reset (async assert, sync release): state=FILL, slot index=0, o_wr_en=0, o_wr_data=0, o_row_valid=0, o_len_err=0, o_s_tready=0 while reset_n low. The first edge after release may accept a beat.
- A beat is accepted when i_s_tvalid && o_s_tready at a rising edge.
- All outputs are registered; no combinational path from inputs to outputs.
- FILL state:
  - o_s_tready=1.
  - On accept at index k: next cycle o_wr_en = 1<<k (single-cycle pulse) and o_wr_data = beat data.
  - The slot register captures the beat on the following edge, i.e. the slot is updated 2 edges after acceptance.
  - o_wr_data holds its last value when no write is in progress.
- Row close: the row closes on the accepted beat at index ROW_LEN-1, or on an accepted beat with tlast at index < ROW_LEN-1.
  - Closing goes FILL->LAST. o_s_tready drops in the cycle after the closing accept, so no further beat is taken.
- LAST state: the final write pulse is in flight; transitions unconditionally to HOLD.
- HOLD state:
  - o_row_valid=1 and o_s_tready=0.
  - When i_row_ack=1: slot index resets to 0 and the state returns to FILL. o_row_valid=0 and o_s_tready=1 from the next cycle.
  - i_row_ack is ignored in FILL and LAST.
- Minimum row period: ROW_LEN accept cycles + LAST + HOLD, i.e. ROW_LEN+2 cycles when ack is immediate.
- Length errors (row still closes as above):
  - tlast on an index < ROW_LEN-1: early. Slots above k are not written and keep stale contents.
  - No tlast on index ROW_LEN-1: late. The following beats form the next row.
  - Either case sets o_len_err the cycle after the offending accept.
- Error clear: o_len_err is cleared by i_err_clr. If i_err_clr and a new error coincide, the error wins and o_len_err stays 1.
- ROW_LEN=1: every accepted beat closes a row. o_len_err is set for any beat without tlast.
- Reset mid-row or in HOLD: everything returns to reset values immediately. An in-flight o_wr_en pulse is killed, and a partially loaded row is discarded with no row_valid.
- Beats offered while o_s_tready=0 are not consumed; i_s_tdata may change freely.

Test Plan:
- Exact packet: ROW_LEN=8, 8 beats 0x10..0x17 back-to-back, tlast on the 8th, ack held 1.
  - o_wr_en pulses 0x01,0x02,..,0x80 on consecutive cycles with matching data.
  - o_row_valid high for 1 cycle, then tready is 1 again; o_len_err stays 0.
- Backpressure: hold i_row_ack=0 for 20 cycles after row close while tvalid=1 with 0xAA.
  - o_s_tready=0 and no o_wr_en activity throughout.
  - Asserting ack gives tready=1 next cycle, and 0xAA is written to slot 0.
- Early tlast: 3 beats 0x1,0x2,0x3, tlast on the 3rd.
  - Only o_wr_en 0x01,0x02,0x04 pulse; o_row_valid rises; o_len_err=1.
  - i_err_clr then drops o_len_err to 0.
- Late/no tlast: 16 beats, tlast only on beat 16.
  - Two rows delivered; o_len_err=1 after the first row.
  - A new error coinciding with i_err_clr keeps o_len_err=1.
- Gapped input: tvalid toggling 1/0 every cycle across 8 beats.
  - Slot order and data preserved; o_row_valid only after the 8th beat's pulse.
- Reset mid-row: drop reset_n asynchronously after 5 beats (between edges).
  - o_wr_en, o_row_valid, o_s_tready go 0 immediately.
  - After release, the next beat is written to slot 0 (o_wr_en=0x01).
